ff_bank_wr_ctrl: RTL and testbench

//   Write sequencer for a bank of NUM_SLOTS write-enabled FF registers, used as a frame buffer.

---
 rtl/ff_bank_wr_ctrl.sv | 85 ++++++++
 tb/tb_ff_bank_wr_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ff_bank_wr_ctrl.sv
// ff_bank_wr_ctrl: sequences a valid/ready sample stream into one-hot write enables for a FF bank.
module ff_bank_wr_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int NUM_SLOTS  = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Start_SI,
    input  logic                  Abort_SI,
    input  logic                  Valid_SI,
    input  logic [DATA_WIDTH-1:0] D_DI,
    output logic                  Ready_SO,
    output logic [NUM_SLOTS-1:0]  WrEn_SO,
    output logic [DATA_WIDTH-1:0] D_DO,
    output logic [IDX_WIDTH:0]    FillCnt_DO,
    output logic                  Done_SO,
    input  logic                  Ack_SI
);
    typedef enum logic [1:0] {IDLE, FILL, FLUSH, FULL} state_e;
    localparam logic [NUM_SLOTS-1:0] ONE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [IDX_WIDTH:0]    cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  wren_q, wren_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  accept, last;
    // Abort wins over a simultaneous valid sample.
    assign accept = (state_q == FILL) && Valid_SI && !Abort_SI;
    assign last   = idx_q == IDX_WIDTH'(NUM_SLOTS - 1);
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wren_d  = accept ? ONE << idx_q : '0;
        data_d  = accept ? D_DI : data_q;
        case (state_q)
            IDLE: if (Start_SI) begin
                state_d = FILL;
                idx_d   = '0;
                cnt_d   = '0;
            end
            FILL: if (Abort_SI) begin
                state_d = IDLE;
            end else if (accept) begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? FLUSH : FILL;
            end
            FLUSH: state_d = FULL;
            FULL: if (Ack_SI) begin
                state_d = Start_SI ? FILL : IDLE;
                if (Start_SI) begin
                    idx_d = '0;
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = state_d == FULL;
    end
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            wren_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end
    assign Ready_SO   = state_q == FILL;
    assign WrEn_SO    = wren_q;
    assign D_DO       = data_q;
    assign FillCnt_DO = cnt_q;
    assign Done_SO    = done_q;
endmodule

// File: tb/tb_ff_bank_wr_ctrl.sv
// tb_ff_bank_wr_ctrl: directed and randomized checks of ff_bank_wr_ctrl against a frame-level model.
module tb_ff_bank_wr_ctrl;
    localparam int DW = 10;
    localparam int N  = 8;
    localparam int IW = 3;
    logic          clk = 0, rst = 1, start = 0, abort = 0, valid = 0, ack = 0;
    logic [DW-1:0] d = '0;
    logic          ready, done;
    logic [N-1:0]  wren;
    logic [DW-1:0] dout;
    logic [IW:0]   fillcnt;
    int            total = 0, passed = 0;

    ff_bank_wr_ctrl #(.DATA_WIDTH(DW), .NUM_SLOTS(N), .IDX_WIDTH(IW)) dut (
        .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .Abort_SI(abort), .Valid_SI(valid),
        .D_DI(d), .Ready_SO(ready), .WrEn_SO(wren), .D_DO(dout), .FillCnt_DO(fillcnt),
        .Done_SO(done), .Ack_SI(ack));

    always #5 clk = ~clk;

    // Frame-level model: is a frame filling, how many samples landed, is the bank waiting for ack.
    bit            m_fill = 0, m_flush = 0, m_full = 0, m_acc;
    int            m_cnt = 0;
    logic [N-1:0]  m_wr = '0;
    logic [N-1:0]  m_one = 1;
    logic [DW-1:0] m_d = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fill = 0; m_flush = 0; m_full = 0; m_cnt = 0; m_wr = '0; m_d = '0;
        end else begin
            m_acc = m_fill && valid && !abort;
            m_wr  = m_acc ? m_one << m_cnt : '0;
            if (m_acc) m_d = d;
            if (m_full) begin
                if (ack) begin
                    m_full = 0;
                    if (start) begin m_fill = 1; m_cnt = 0; end
                end
            end else if (m_flush) begin
                m_flush = 0; m_full = 1;
            end else if (m_fill) begin
                if (abort) m_fill = 0;
                else if (m_acc) begin
                    m_cnt++;
                    if (m_cnt == N) begin m_fill = 0; m_flush = 1; end
                end
            end else if (start) begin
                m_fill = 1; m_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(m_fill));
        chk("wren", 32'(wren), 32'(m_wr));
        chk("dout", 32'(dout), 32'(m_d));
        chk("fillcnt", 32'(fillcnt), 32'(m_cnt));
        chk("done", 32'(done), 32'(m_full));
    end

    task automatic cyc(input logic s, input logic ab, input logic v, input logic [DW-1:0] x, input logic ak);
        start = s; abort = ab; valid = v; d = x; ack = ak;
        @(posedge clk);
        #2;
        start = 0; abort = 0; valid = 0; ack = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk("rst_wren", 32'(wren), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(ready), 0);
        // Full frame 1..8
        cyc(1, 0, 0, 0, 0);
        chk("start_ready", 32'(ready), 1);
        for (int i = 1; i <= N; i++) begin
            cyc(0, 0, 1, DW'(i), 0);
            chk("frame_wren", 32'(wren), 32'(1) << (i - 1));
            chk("frame_dout", 32'(dout), 32'(i));
        end
        chk("flush_ready", 32'(ready), 0);
        chk("flush_done", 32'(done), 0);
        cyc(0, 0, 0, 0, 0);
        chk("full_done", 32'(done), 1);
        chk("full_wren", 32'(wren), 0);
        chk("full_cnt", 32'(fillcnt), 8);
        // Held in FULL without ack
        cyc(1, 1, 1, 10'd99, 0);
        chk("hold_done", 32'(done), 1);
        chk("hold_wren", 32'(wren), 0);
        chk("hold_dout", 32'(dout), 8);
        // Ack+Start back-to-back
        cyc(1, 0, 0, 0, 1);
        chk("b2b_done", 32'(done), 0);
        chk("b2b_ready", 32'(ready), 1);
        chk("b2b_cnt", 32'(fillcnt), 0);
        cyc(0, 0, 1, 10'd3, 0);
        chk("b2b_wren", 32'(wren), 32'h01);
        cyc(0, 0, 1, 10'd4, 0);
        cyc(0, 0, 1, 10'd5, 0);
        // Abort with valid same cycle
        cyc(0, 1, 1, 10'd6, 0);
        chk("abort_wren", 32'(wren), 0);
        chk("abort_ready", 32'(ready), 0);
        chk("abort_cnt", 32'(fillcnt), 3);
        chk("abort_dout", 32'(dout), 5);
        // Gapped valid
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 10'h3FB, 0);
        chk("gap_wren0", 32'(wren), 32'h01);
        chk("gap_dout0", 32'(dout), 32'h3FB);
        cyc(0, 0, 0, 10'd1, 0);
        chk("gap_wren1", 32'(wren), 0);
        cyc(0, 0, 1, 10'd7, 0);
        chk("gap_wren2", 32'(wren), 32'h02);
        cyc(0, 0, 0, 0, 0);
        chk("gap_wren3", 32'(wren), 0);
        // Async reset mid-fill, with a pulse just registered
        cyc(0, 0, 1, 10'd9, 0);
        #1 rst = 1;
        #1;
        chk("arst_wren", 32'(wren), 0);
        chk("arst_dout", 32'(dout), 0);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_cnt", 32'(fillcnt), 0);
        @(posedge clk);
        #2 rst = 0;
        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 599) == 0);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                DW'($urandom), $urandom_range(0, 3) == 0);
        end
        rst = 0;
        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
